// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// The optional perf counters are enabled with the macro MEM_PORT_ARBITER_PERF_EN.
package mem_port_arbiter_pkg;

  // Arbiter FSM: idle, fetch outstanding, data outstanding, cancelled fetch outstanding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DROP   = 2'd3
  } mem_arb_state_e;

  // Wide all-ones byte-enable mask; users slice it down to their byte-enable width
  localparam logic [63:0] MEM_ARB_FULL_BE = {64{1'b1}};

  // Saturating increment used by the 32-bit performance counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/mem_arb_perf_counter.sv
// Single 32-bit saturating event counter for the arbiter performance taps.
module mem_arb_perf_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: bump by one on an event, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = sat_inc32(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (instruction) and memory-access (data)
// requesters with one transaction outstanding. Data has priority; a starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants.
// Flush cancels a pending or in-flight fetch and silently drops its response.
// Define MEM_PORT_ARBITER_PERF_EN to build the conflict/drop counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    imem_req,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic                    imem_gnt,
  output logic                    imem_rvalid,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  input  logic                    dmem_req,
  input  logic                    dmem_we,
  input  logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic                    dmem_gnt,
  output logic                    dmem_rvalid,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [31:0]             perf_conflict_cnt,
  output logic [31:0]             perf_drop_cnt
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  mem_arb_state_e state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           issue_win_s;
  logic           sel_i_s;
  logic           sel_d_s;
  mem_req_t       req_s;

  // Issue window and request selection; everything is held quiet in reset
  always_comb begin
    issue_win_s = 1'b0;
    sel_i_s     = 1'b0;
    sel_d_s     = 1'b0;
    req_s       = '0;
    if (rst) begin
      // IDLE always issues; a busy state issues in its completing cycle
      issue_win_s = (state_q == IDLE) || mem_rvalid;
    end else begin
      issue_win_s = 1'b0;
    end
    sel_i_s = issue_win_s && imem_req && !flush &&
              (!dmem_req || (starve_q == STARVE_MAX));
    sel_d_s = issue_win_s && dmem_req && !sel_i_s;
    if (sel_i_s) begin
      req_s.we    = 1'b0;
      req_s.be    = MEM_ARB_FULL_BE[BE_W-1:0];
      req_s.addr  = imem_addr;
      req_s.wdata = '0;
    end else if (sel_d_s) begin
      req_s.we    = dmem_we;
      req_s.be    = dmem_be;
      req_s.addr  = dmem_addr;
      req_s.wdata = dmem_wdata;
    end else begin
      req_s = '0;
    end
  end

  assign mem_req   = sel_i_s || sel_d_s;
  assign mem_we    = req_s.we;
  assign mem_be    = req_s.be;
  assign mem_addr  = req_s.addr;
  assign mem_wdata = req_s.wdata;
  assign imem_gnt  = sel_i_s && mem_ready;
  assign dmem_gnt  = sel_d_s && mem_ready;

  // Responses pass straight through; a flush in the completing cycle kills the fetch data
  assign imem_rvalid = (state_q == BUSY_I) && mem_rvalid && !flush;
  assign dmem_rvalid = (state_q == BUSY_D) && mem_rvalid;
  assign imem_rdata  = imem_rvalid ? mem_rdata : '0;
  assign dmem_rdata  = dmem_rvalid ? mem_rdata : '0;

  // Next state and starvation counter
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (imem_gnt) begin
      state_d = BUSY_I;
    end else if (dmem_gnt) begin
      state_d = BUSY_D;
    end else if (issue_win_s) begin
      state_d = IDLE;
    end else if ((state_q == BUSY_I) && flush) begin
      state_d = DROP;
    end else begin
      state_d = state_q;
    end
    if (!imem_req || imem_gnt) begin
      starve_d = '0;
    end else if (dmem_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbiter FSM and starvation counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic conflict_inc_s;
  logic drop_inc_s;

  assign conflict_inc_s = imem_req && dmem_req && !(imem_gnt || dmem_gnt);
  assign drop_inc_s     = mem_rvalid &&
                          ((state_q == DROP) || ((state_q == BUSY_I) && flush));

  mem_arb_perf_counter u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (conflict_inc_s),
    .cnt_o (perf_conflict_cnt)
  );

  mem_arb_perf_counter u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_inc_s),
    .cnt_o (perf_drop_cnt)
  );
`else
  assign perf_conflict_cnt = 32'd0;
  assign perf_drop_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory with programmable
// latency, a response scoreboard, a grant-order vector table and corner sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] perf_conflict_cnt, perf_drop_cnt;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .perf_conflict_cnt(perf_conflict_cnt), .perf_drop_cnt(perf_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
    logic        cancel;
  } exp_t;

  typedef struct {
    logic ir;
    logic dr;
    logic rdy;
    logic eig;
    logic edg;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  logic pend = 1'b0;
  int resp_cyc = -1;
  logic [31:0] resp_data = 32'd0;
  logic s_ig, s_dg, s_ir, s_dr, s_mreq, s_mwe;
  logic [3:0] s_mbe;
  logic [31:0] s_maddr, s_mwdata, s_ird;
  logic [31:0] exp_drop, exp_conf;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0000_DEAD : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: memory model drives response, outputs sampled mid-cycle, scoreboard updated
  task automatic tick();
    exp_t e;
    @(negedge clk);
    mem_rvalid = pend && (cyc == resp_cyc);
    mem_rdata  = mem_rvalid ? resp_data : 32'h1234_5678;
    #1;
    if (flush && (sb.size() > 0) && sb[0].is_i) begin
      e = sb[0];
      e.cancel = 1'b1;
      sb[0] = e;
    end
    if (mem_rvalid) begin
      pend = 1'b0;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_rvalid", 32'(imem_rvalid), 32'(e.is_i && !e.cancel));
        chk("dmem_rvalid", 32'(dmem_rvalid), 32'(!e.is_i));
        if (e.is_i && !e.cancel) chk("imem_rdata", imem_rdata, e.data);
        if (!e.is_i) chk("dmem_rdata", dmem_rdata, e.data);
      end else begin
        chk("stray_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
      end
    end else begin
      chk("quiet_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
    end
    s_ig = imem_gnt;  s_dg = dmem_gnt;  s_ir = imem_rvalid;  s_dr = dmem_rvalid;
    s_ird = imem_rdata;  s_mreq = mem_req;  s_mwe = mem_we;  s_mbe = mem_be;
    s_maddr = mem_addr;  s_mwdata = mem_wdata;
    chk("accept_vs_gnt", 32'(mem_req && mem_ready), 32'(s_ig || s_dg));
    if (s_ig) begin
      chk("i_fields", {mem_addr[27:0], mem_we, mem_be[2:0]}, {imem_addr[27:0], 1'b0, 3'b111});
      sb.push_back('{1'b1, mem_word(imem_addr), 1'b0});
    end
    if (s_dg) begin
      chk("d_addr", mem_addr, dmem_addr);
      chk("d_we_be", {27'd0, mem_we, mem_be}, {27'd0, dmem_we, dmem_be});
      sb.push_back('{1'b0, mem_word(dmem_addr), 1'b0});
    end
    if (mem_req && mem_ready) begin
      pend = 1'b1;
      resp_cyc = cyc + lat;
      resp_data = mem_word(mem_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drop all requests and run until every expected response has been seen
  task automatic drain();
    int n = 0;
    imem_req = 1'b0;  dmem_req = 1'b0;  flush = 1'b0;  mem_ready = 1'b1;
    while ((sb.size() > 0) && (n < 20)) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef MEM_PORT_ARBITER_PERF_EN
    exp_drop = 32'd1;
    exp_conf = 32'd1;
`else
    exp_drop = 32'd0;
    exp_conf = 32'd0;
`endif
    rst = 1'b0;  flush = 1'b0;
    imem_req = 1'b1;  imem_addr = 32'h0000_0100;
    dmem_req = 1'b1;  dmem_we = 1'b0;  dmem_be = 4'hF;
    dmem_addr = 32'h0000_0300;  dmem_wdata = 32'd0;
    mem_ready = 1'b1;  mem_rvalid = 1'b0;  mem_rdata = 32'd0;

    // Reset state: all outputs quiet even with both requests raised
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_outputs", {26'd0, s_mreq, s_ig, s_dg, s_ir, s_dr, s_mwe}, 32'd0);
      chk("rst_mem_addr", s_maddr, 32'd0);
      chk("rst_perf", perf_conflict_cnt | perf_drop_cnt, 32'd0);
    end
    rst = 1'b1;  imem_req = 1'b0;  dmem_req = 1'b0;

    // Single fetch, 2-cycle memory
    lat = 2;
    imem_req = 1'b1;  imem_addr = 32'h0000_0100;
    tick();  chk("t1_ignt", {30'd0, s_ig, s_dg}, 32'd2);
    imem_req = 1'b0;  dmem_req = 1'b1;
    tick();  chk("t1_busy_no_dgnt", 32'(s_dg), 32'd0);
    dmem_req = 1'b0;
    tick();  chk("t1_rvalid", 32'(s_ir), 32'd1);  chk("t1_rdata", s_ird, 32'h0000_DEAD);
    dmem_req = 1'b1;
    tick();  chk("t1_idle_dgnt", 32'(s_dg), 32'd1);
    drain();

    // Grant-order table: starvation limit, single requesters, ready low
    for (int i = 0; i < 10; i++) begin
      vt[i] = '{1'b1, 1'b1, 1'b1, (i == 4) || (i == 9), !((i == 4) || (i == 9))};
    end
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    lat = 1;
    imem_addr = 32'h0000_0200;  dmem_addr = 32'h0000_0300;  dmem_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem_req = vt[i].ir;  dmem_req = vt[i].dr;  mem_ready = vt[i].rdy;
      tick();
      chk($sformatf("tbl_gnt[%0d]", i), {30'd0, s_ig, s_dg}, {30'd0, vt[i].eig, vt[i].edg});
    end
    drain();

    // Flush one cycle after a fetch grant: response dropped
    lat = 2;
    imem_req = 1'b1;  imem_addr = 32'h0000_0400;
    tick();  chk("t3_ignt", 32'(s_ig), 32'd1);
    imem_req = 1'b0;  flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();  chk("t3_no_rvalid", 32'(s_ir), 32'd0);
    chk("t3_drop_cnt", perf_drop_cnt, exp_drop);
    drain();

    // Flush coincident with the fetch response while data waits
    imem_req = 1'b1;  imem_addr = 32'h0000_0500;
    tick();  chk("t4_ignt", 32'(s_ig), 32'd1);
    imem_req = 1'b0;  dmem_req = 1'b1;  dmem_addr = 32'h0000_0600;
    tick();  chk("t4_busy_no_dgnt", 32'(s_dg), 32'd0);
    flush = 1'b1;
    tick();  chk("t4_no_irvalid", 32'(s_ir), 32'd0);  chk("t4_dgnt", 32'(s_dg), 32'd1);
    drain();
    chk("t4_drop_cnt", perf_drop_cnt, exp_drop << 1);

    // Store held while memory is not ready
    lat = 1;
    dmem_req = 1'b1;  dmem_we = 1'b1;  dmem_be = 4'b0011;
    dmem_addr = 32'h0000_0040;  dmem_wdata = 32'hCAFE_BABE;  mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_hold_ctl", {27'd0, s_mreq, s_mwe, s_dg, s_mbe[1:0]}, {27'd0, 1'b1, 1'b1, 1'b0, 2'b11});
      chk("t5_hold_be_hi", {30'd0, s_mbe[3:2]}, 32'd0);
      chk("t5_hold_addr", s_maddr, 32'h0000_0040);
      chk("t5_hold_wdata", s_mwdata, 32'hCAFE_BABE);
    end
    mem_ready = 1'b1;
    tick();  chk("t5_dgnt", 32'(s_dg), 32'd1);
    drain();
    dmem_we = 1'b0;  dmem_be = 4'hF;
    chk("conflict_cnt", perf_conflict_cnt, exp_conf);

    // Reset during a data transaction; late response must be ignored
    lat = 3;
    dmem_req = 1'b1;  dmem_addr = 32'h0000_0700;
    tick();  chk("t6_dgnt", 32'(s_dg), 32'd1);
    dmem_req = 1'b0;
    tick();
    rst = 1'b0;  sb.delete();  imem_req = 1'b1;  dmem_req = 1'b1;
    tick();
    chk("t6_rst_outputs", {27'd0, s_mreq, s_ig, s_dg, s_ir, s_dr}, 32'd0);
    chk("t6_rst_perf", perf_conflict_cnt | perf_drop_cnt, 32'd0);
    rst = 1'b1;  imem_req = 1'b0;  dmem_req = 1'b0;
    tick();  chk("t6_stray_drvalid", 32'(s_dr), 32'd0);
    lat = 1;
    imem_req = 1'b1;  imem_addr = 32'h0000_0800;
    tick();  chk("t6_after_ignt", 32'(s_ig), 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single shared memory port between the fetch stage (instruction requester) and the memory-access stage (data requester), with at most one transaction outstanding. Data requests have priority; a starvation limit guarantees forward progress for fetch. A flush input from the pipeline controller, asserted on irregular-PC redirect, cancels an in-flight instruction fetch so that its stale response is discarded. Sits between FetchStage/MemoryAccessStage and the unified memory.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits (minimum 1)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  pipeline redirect; cancels pending and in-flight instruction fetch
imem_req  in  1  fetch requests a read
imem_addr  in  ADDR_WIDTH  fetch address
imem_gnt  out  1  fetch request accepted by memory this cycle
imem_rvalid  out  1  fetch read data valid
imem_rdata  out  DATA_WIDTH  fetch read data
dmem_req  in  1  data access request
dmem_we  in  1  1 = store, 0 = load
dmem_be  in  DATA_WIDTH/8  store byte enables
dmem_addr  in  ADDR_WIDTH  data address
dmem_wdata  in  DATA_WIDTH  store data
dmem_gnt  out  1  data request accepted this cycle
dmem_rvalid  out  1  data response valid (load data, or store ack)
dmem_rdata  out  DATA_WIDTH  load data
mem_req  out  1  request to memory
mem_we  out  1  write enable
mem_be  out  DATA_WIDTH/8  byte enables (all ones for fetch)
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  write data
mem_ready  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  memory response valid, at least 1 cycle after accept
mem_rdata  in  DATA_WIDTH  memory read data
perf_conflict_cnt  out  32  cycles in which both requesters wait (optional feature)
perf_drop_cnt  out  32  instruction responses discarded by flush (optional feature)

Behaviour:
- Reset values: state IDLE, starve counter 0, all outputs 0.
- FSM states: IDLE, BUSY_I (fetch outstanding), BUSY_D (data outstanding), DROP (cancelled fetch outstanding).
- Issue window: IDLE, or any BUSY state in the cycle mem_rvalid=1. This allows back-to-back issue with no bubble.
- Selection within the issue window:
  - Data wins by default.
  - Instruction wins if dmem_req=0, or if starve counter == STARVE_LIMIT and imem_req=1.
  - The fetch candidate is masked while flush=1.
- mem_req is combinational from the selected request. gnt is asserted only when mem_req && mem_ready; state then moves to BUSY_I or BUSY_D. With no grant, the state returns to IDLE.
- Starve counter:
  - +1 on each data grant while imem_req=1, saturating at STARVE_LIMIT.
  - Cleared on instruction grant, or when imem_req=0.
- Response routing: in BUSY_I, mem_rvalid drives imem_rvalid with rdata passthrough (0 latency from mem_rvalid); likewise BUSY_D to dmem.
- In IDLE, mem_rvalid is ignored. This covers stray responses after reset.
- Flush:
  - In BUSY_I (without mem_rvalid): go to DROP.
  - Coincident with mem_rvalid in BUSY_I: imem_rvalid suppressed.
  - In DROP: mem_rvalid is consumed silently, with no requester rvalid.
  - Flush never affects data transactions.
- Reset mid-transaction returns to IDLE immediately. Memory responses to the aborted transaction are dropped by the IDLE rule.
- Requesters hold req/addr/wdata stable until gnt. The arbiter does not register requests.

Optional Feature:
MEM_PORT_ARBITER_PERF_EN
- Defined: two saturating 32-bit counters.
  - perf_conflict_cnt increments each cycle with imem_req && dmem_req && no grant.
  - perf_drop_cnt increments each DROP-state response and each suppressed coincident response.
  - Both reset to 0.
- Undefined: ports remain present, tied to 0; no counter flops.

Decomposition:
- Package MemArbTypes:
  - enum MemArbState {IDLE, BUSY_I, BUSY_D, DROP}
  - struct MemReq {we, be, addr, wdata}
  - constant MEM_ARB_FULL_BE
- Sub-module mem_arb_perf_counter: one saturating counter with inc input, instantiated twice under the macro.

Test Plan:
- Only imem_req=1 at 0x100, mem_ready=1, rvalid 2 cycles later with 0xDEAD -> imem_gnt in cycle 0, imem_rvalid=1 with 0xDEAD in cycle 2, state IDLE after.
- Both requests held continuously, STARVE_LIMIT=4, fixed 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I.
- Fetch granted, flush in next cycle, rvalid a cycle later -> imem_rvalid stays 0; perf_drop_cnt=1 when the macro is defined.
- Flush coincident with mem_rvalid in BUSY_I while dmem_req=1 -> imem_rvalid=0, dmem_gnt=1 in the same cycle.
- Store at 0x40 with be=4'b0011, mem_ready low for 3 cycles -> mem_req held 3 cycles with stable fields, dmem_gnt only in the 4th cycle.
- rst asserted in BUSY_D, memory returns rvalid after release -> outputs 0 during reset, dmem_rvalid never asserted.
